// File: rtl/clock_pkg.sv
// Shared BCD time-of-day types, limits and helpers for the clock datapath.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t hr_t;
    bcd_digit_t hr_o;
    bcd_digit_t min_t;
    bcd_digit_t min_o;
    bcd_digit_t sec_t;
    bcd_digit_t sec_o;
  } bcd_time_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;

  // Two-digit BCD value with both digits legal and not above limit; with legal
  // digits a plain binary compare orders BCD values correctly.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] limit);
    return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= limit);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] val);
    if (val[3:0] == 4'd9) begin
      return {val[7:4] + 4'd1, 4'd0};
    end
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from Top to WrapVal; wrap_o is the combinational
// carry so the next stage can advance on the same edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] Top     = SEC_MAX,
  parameter logic [7:0] WrapVal = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       ld_i,
  input  logic [7:0] ld_val_i,
  output logic [7:0] q_o,
  output logic       wrap_o
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d    = q_q;
    wrap_o = 1'b0;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (inc_i) begin
      if (q_q == Top) begin
        q_d    = WrapVal;
        wrap_o = 1'b1;
      end else begin
        q_d = bcd_inc(q_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= WrapVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_tod_counter.sv
// Synchronous BCD HH:MM:SS counter with seconds prescaler, 12/24h hours,
// validated preset load and HH:MM alarm.
module bcd_tod_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter bit          MODE_12H      = 1'b0,
  parameter bit          ALARM_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  input  logic        load,
  input  logic [23:0] t_in,
  input  logic        pm_in,
  input  logic        alarm_set,
  input  logic [15:0] alarm_in,
  output logic [23:0] t_out,
  output logic        pm,
  output logic        sec_tick,
  output logic        min_carry,
  output logic        hour_carry,
  output logic        day_wrap,
  output logic        load_err,
  output logic        alarm_hit
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PresLast = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] HourRst = MODE_12H ? HR12_MAX : 8'h00;

  function automatic logic hour_ok(input logic [7:0] h);
    if (MODE_12H) return bcd_valid(h, HR12_MAX) && (h >= HR12_MIN);
    return bcd_valid(h, HR24_MAX);
  endfunction

  bcd_time_t  t_in_s;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] sec_q, min_q, hour_q, hour_d, min_next;
  logic       pm_q, pm_d, day_d;
  logic       tick, run_tick, load_ok, alarm_ok, sec_wrap, min_wrap;
  logic [15:0] alarm_q;
  logic       alarm_pm_q, alarm_hit_d;

  assign t_in_s   = bcd_time_t'(t_in);
  assign tick     = en && (presc_q == PresLast);
  assign load_ok  = load && hour_ok({t_in_s.hr_t, t_in_s.hr_o})
                  && bcd_valid({t_in_s.min_t, t_in_s.min_o}, MIN_MAX)
                  && bcd_valid({t_in_s.sec_t, t_in_s.sec_o}, SEC_MAX);
  assign alarm_ok = ALARM_EN && alarm_set && hour_ok(alarm_in[15:8])
                  && bcd_valid(alarm_in[7:0], MIN_MAX);
  // An accepted load swallows a coincident tick, carries included.
  assign run_tick = tick && !load_ok;

  always_comb begin
    presc_d = presc_q;
    if (load_ok) presc_d = '0;
    else if (tick) presc_d = '0;
    else if (en) presc_d = presc_q + PW'(1);
  end

  bcd_mod_counter #(.Top(SEC_MAX), .WrapVal(8'h00)) u_sec (
    .clk_i    (clk),
    .rst_ni   (clr_n),
    .inc_i    (run_tick),
    .ld_i     (load_ok),
    .ld_val_i (t_in[7:0]),
    .q_o      (sec_q),
    .wrap_o   (sec_wrap)
  );

  bcd_mod_counter #(.Top(MIN_MAX), .WrapVal(8'h00)) u_min (
    .clk_i    (clk),
    .rst_ni   (clr_n),
    .inc_i    (sec_wrap),
    .ld_i     (load_ok),
    .ld_val_i (t_in[15:8]),
    .q_o      (min_q),
    .wrap_o   (min_wrap)
  );

  always_comb begin
    hour_d = hour_q;
    pm_d   = pm_q;
    day_d  = 1'b0;
    if (load_ok) begin
      hour_d = t_in[23:16];
      pm_d   = MODE_12H ? pm_in : 1'b0;
    end else if (min_wrap) begin
      if (MODE_12H) begin
        if (hour_q == 8'h11) begin
          hour_d = HR12_MAX;
          pm_d   = ~pm_q;
          day_d  = pm_q;
        end else if (hour_q == HR12_MAX) begin
          hour_d = HR12_MIN;
        end else begin
          hour_d = bcd_inc(hour_q);
        end
      end else if (hour_q == HR24_MAX) begin
        hour_d = 8'h00;
        day_d  = 1'b1;
      end else begin
        hour_d = bcd_inc(hour_q);
      end
    end
  end

  // Alarm fires only on a tick that lands on HH:MM:00, never on a load.
  assign min_next    = min_wrap ? 8'h00 : bcd_inc(min_q);
  assign alarm_hit_d = ALARM_EN && sec_wrap && ({hour_d, min_next} == alarm_q)
                     && (!MODE_12H || (pm_d == alarm_pm_q));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc_q    <= '0;
      hour_q     <= HourRst;
      pm_q       <= 1'b0;
      alarm_q    <= {HourRst, 8'h00};
      alarm_pm_q <= 1'b0;
      sec_tick   <= 1'b0;
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_wrap   <= 1'b0;
      load_err   <= 1'b0;
      alarm_hit  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      pm_q       <= pm_d;
      if (alarm_ok) begin
        alarm_q    <= alarm_in;
        alarm_pm_q <= MODE_12H ? pm_in : 1'b0;
      end
      sec_tick   <= run_tick;
      min_carry  <= sec_wrap;
      hour_carry <= min_wrap;
      day_wrap   <= day_d;
      load_err   <= (load && !load_ok) || (ALARM_EN && alarm_set && !alarm_ok);
      alarm_hit  <= alarm_hit_d;
    end
  end

  assign t_out = {hour_q, min_q, sec_q};
  assign pm    = MODE_12H ? pm_q : 1'b0;

endmodule

// File: tb/tb_bcd_tod_counter.sv
// Directed bench: 24h/alarm, 12h and 24h/no-alarm instances share one stimulus stream.
module tb_bcd_tod_counter;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [23:0] t_in = '0;
  logic        pm_in = 1'b0;
  logic        alarm_set = 1'b0;
  logic [15:0] alarm_in = '0;

  logic [23:0] a_t, b_t, c_t;
  logic a_pm, a_st, a_mc, a_hc, a_dw, a_le, a_ah;
  logic b_pm, b_st, b_mc, b_hc, b_dw, b_le, b_ah;
  logic c_pm, c_st, c_mc, c_hc, c_dw, c_le, c_ah;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_tod_counter #(.TICKS_PER_SEC(4), .MODE_12H(1'b0), .ALARM_EN(1'b1)) u_a (
    .clk(clk), .clr_n(clr_n), .en(en), .load(load), .t_in(t_in), .pm_in(pm_in),
    .alarm_set(alarm_set), .alarm_in(alarm_in), .t_out(a_t), .pm(a_pm),
    .sec_tick(a_st), .min_carry(a_mc), .hour_carry(a_hc), .day_wrap(a_dw),
    .load_err(a_le), .alarm_hit(a_ah)
  );

  bcd_tod_counter #(.TICKS_PER_SEC(4), .MODE_12H(1'b1), .ALARM_EN(1'b1)) u_b (
    .clk(clk), .clr_n(clr_n), .en(en), .load(load), .t_in(t_in), .pm_in(pm_in),
    .alarm_set(alarm_set), .alarm_in(alarm_in), .t_out(b_t), .pm(b_pm),
    .sec_tick(b_st), .min_carry(b_mc), .hour_carry(b_hc), .day_wrap(b_dw),
    .load_err(b_le), .alarm_hit(b_ah)
  );

  bcd_tod_counter #(.TICKS_PER_SEC(4), .MODE_12H(1'b0), .ALARM_EN(1'b0)) u_c (
    .clk(clk), .clr_n(clr_n), .en(en), .load(load), .t_in(t_in), .pm_in(pm_in),
    .alarm_set(alarm_set), .alarm_in(alarm_in), .t_out(c_t), .pm(c_pm),
    .sec_tick(c_st), .min_carry(c_mc), .hour_carry(c_hc), .day_wrap(c_dw),
    .load_err(c_le), .alarm_hit(c_ah)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sample #1 after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] val, input logic p);
    load  = 1'b1;
    t_in  = val;
    pm_in = p;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    // Reset and first ticks
    step(2);
    check("rst_t24", {8'h0, a_t}, 32'h000000);
    check("rst_t12", {8'h0, b_t}, 32'h120000);
    check("rst_pm12", {31'h0, b_pm}, 32'h0);
    check("rst_tick", {31'h0, a_st}, 32'h0);
    clr_n = 1'b1;
    step(3);
    check("pre_tick_t", {8'h0, a_t}, 32'h000000);
    check("pre_tick_st", {31'h0, a_st}, 32'h0);
    step(1);
    check("tick1_t", {8'h0, a_t}, 32'h000001);
    check("tick1_st", {31'h0, a_st}, 32'h1);
    step(1);
    check("tick1_st_drop", {31'h0, a_st}, 32'h0);
    step(3);
    check("tick2_t", {8'h0, a_t}, 32'h000002);

    // Midnight rollover in 24h; reset alarm 00:00 is armed
    do_load(24'h235958, 1'b0);
    check("ld_235958", {8'h0, a_t}, 32'h235958);
    step(4);
    check("t_235959", {8'h0, a_t}, 32'h235959);
    check("no_mc_yet", {31'h0, a_mc}, 32'h0);
    step(4);
    check("wrap_t", {8'h0, a_t}, 32'h000000);
    check("wrap_flags", {28'h0, a_mc, a_hc, a_dw, a_st}, 32'hF);
    check("wrap_alarm_rst", {31'h0, a_ah}, 32'h1);
    check("wrap_noalarm", {31'h0, c_ah}, 32'h0);
    check("ld_err_12h", {31'h0, b_le}, 32'h0);

    // 12h sequencing
    do_load(24'h115959, 1'b0);
    check("ld12_t", {8'h0, b_t}, 32'h115959);
    step(4);
    check("am_to_pm_t", {8'h0, b_t}, 32'h120000);
    check("am_to_pm_pm", {31'h0, b_pm}, 32'h1);
    check("am_to_pm_dw", {31'h0, b_dw}, 32'h0);
    check("pm24_zero", {31'h0, a_pm}, 32'h0);
    do_load(24'h115959, 1'b1);
    step(4);
    check("pm_to_am_t", {8'h0, b_t}, 32'h120000);
    check("pm_to_am_pm", {31'h0, b_pm}, 32'h0);
    check("pm_to_am_dw", {31'h0, b_dw}, 32'h1);
    do_load(24'h125959, 1'b1);
    step(4);
    check("12_to_01_t", {8'h0, b_t}, 32'h010000);
    check("12_to_01_pm", {31'h0, b_pm}, 32'h1);

    // Rejected loads with the time frozen
    do_load(24'h101010, 1'b0);
    en = 1'b0;
    do_load(24'h006000, 1'b0);
    check("err_min60", {31'h0, a_le}, 32'h1);
    check("err_min60_t", {8'h0, a_t}, 32'h101010);
    step(1);
    check("err_pulse_end", {31'h0, a_le}, 32'h0);
    do_load(24'h240000, 1'b0);
    check("err_hr24", {31'h0, a_le}, 32'h1);
    check("err_hr24_12h", {31'h0, b_le}, 32'h1);
    do_load(24'h1A0000, 1'b0);
    check("err_digit", {31'h0, a_le}, 32'h1);
    check("err_digit_t", {8'h0, a_t}, 32'h101010);

    // Load overriding a tick
    en = 1'b1;
    do_load(24'h101010, 1'b0);
    step(3);
    do_load(24'h120000, 1'b0);
    check("ld_vs_tick_t", {8'h0, a_t}, 32'h120000);
    check("ld_vs_tick_st", {31'h0, a_st}, 32'h0);
    step(3);
    check("post_ld_hold", {8'h0, a_t}, 32'h120000);
    step(1);
    check("post_ld_tick", {8'h0, a_t}, 32'h120001);

    // Alarm set together with a load
    alarm_set = 1'b1;
    alarm_in  = 16'h0001;
    do_load(24'h000058, 1'b0);
    alarm_set = 1'b0;
    check("al_ld_no_hit", {31'h0, a_ah}, 32'h0);
    step(4);
    check("al_t59", {8'h0, a_t}, 32'h000059);
    check("al_59_nohit", {31'h0, a_ah}, 32'h0);
    step(4);
    check("al_t100", {8'h0, a_t}, 32'h000100);
    check("al_hit", {31'h0, a_ah}, 32'h1);
    check("al_dis_hit", {31'h0, c_ah}, 32'h0);
    step(1);
    check("al_hit_end", {31'h0, a_ah}, 32'h0);
    step(3);
    check("al_t101", {8'h0, a_t}, 32'h000101);
    check("al_101_nohit", {31'h0, a_ah}, 32'h0);

    // en low mid-second stretches the second by exactly the hold time
    step(2);
    en = 1'b0;
    step(10);
    check("en_hold_t", {8'h0, a_t}, 32'h000101);
    check("en_hold_st", {31'h0, a_st}, 32'h0);
    en = 1'b1;
    step(1);
    check("en_resume_wait", {8'h0, a_t}, 32'h000101);
    step(1);
    check("en_resume_t", {8'h0, a_t}, 32'h000102);
    check("en_resume_st", {31'h0, a_st}, 32'h1);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check("arst_t24", {8'h0, a_t}, 32'h000000);
    check("arst_t12", {8'h0, b_t}, 32'h120000);
    check("arst_pm12", {31'h0, b_pm}, 32'h0);
    check("arst_pulses", {26'h0, a_st, a_mc, a_hc, a_dw, a_le, a_ah}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
